// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester-side and cache-side signals of the memory-port arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the cache.
interface mem_port_arbiter_if #(
    parameter int N_CH = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [N_CH-1:0]    req_valid;
    logic [N_CH-1:0]    req_we;
    logic [N_CH*AW-1:0] req_addr;
    logic [N_CH*DW-1:0] req_wdata;
    logic [N_CH-1:0]    req_ack;
    logic [N_CH-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic [N_CH-1:0]    stall;
    logic               cache_ren;
    logic               cache_wen;
    logic [AW-1:0]      cache_addr;
    logic [DW-1:0]      cache_dout;
    logic [DW-1:0]      cache_din;
    logic               cache_rdy;
    logic               err_timeout;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, cache_din, cache_rdy,
        output req_ack, rsp_valid, rsp_rdata, stall,
        output cache_ren, cache_wen, cache_addr, cache_dout, err_timeout
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, cache_din, cache_rdy,
        input  req_ack, rsp_valid, rsp_rdata, stall,
        input  cache_ren, cache_wen, cache_addr, cache_dout, err_timeout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter in front of a single cache port: one access in flight at a time,
// round-robin or fixed priority, with a BUSY watchdog and a sticky timeout flag.
module mem_port_arbiter #(
    parameter int N_CH       = 2,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0,
    parameter int TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW:0]   NCH_W = (CW+1)'(N_CH);
    localparam logic [TW-1:0] TLIM  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_reg;
    logic [CW-1:0]     ch_reg;
    logic [CW-1:0]     rr_ptr_reg;
    logic              we_reg;
    logic [TW-1:0]     tcnt_reg;
    logic [N_CH-1:0]   rsp_valid_reg;
    logic [DW-1:0]     rsp_rdata_reg;
    logic              cache_ren_reg;
    logic              cache_wen_reg;
    logic [AW-1:0]     cache_addr_reg;
    logic [DW-1:0]     cache_dout_reg;
    logic              err_reg;

    logic [AW-1:0]     ch_addr  [N_CH];
    logic [DW-1:0]     ch_wdata [N_CH];
    logic              grant_valid;
    logic [CW-1:0]     grant_ch;
    logic [CW:0]       cand;
    logic [N_CH-1:0]   req_ack_next;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
            assign ch_addr[gi]  = bus.req_addr[gi*AW +: AW];
            assign ch_wdata[gi] = bus.req_wdata[gi*DW +: DW];
        end
    endgenerate

    // Scan starts at rr_ptr (round-robin) or at 0 (fixed); first requester found wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_ch    = '0;
        cand        = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (FIXED_PRIO != 0) begin
                cand = (CW+1)'(k);
            end else begin
                cand = {1'b0, rr_ptr_reg} + (CW+1)'(k);
                if (cand >= NCH_W) cand = cand - NCH_W;
            end
            if (!grant_valid && bus.req_valid[cand[CW-1:0]]) begin
                grant_valid = 1'b1;
                grant_ch    = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        req_ack_next = '0;
        if (state_reg == IDLE && grant_valid) req_ack_next[grant_ch] = 1'b1;
    end

    assign bus.req_ack     = req_ack_next;
    assign bus.rsp_valid   = rsp_valid_reg;
    assign bus.rsp_rdata   = rsp_rdata_reg;
    assign bus.stall       = bus.req_valid & ~rsp_valid_reg;
    assign bus.cache_ren   = cache_ren_reg;
    assign bus.cache_wen   = cache_wen_reg;
    assign bus.cache_addr  = cache_addr_reg;
    assign bus.cache_dout  = cache_dout_reg;
    assign bus.err_timeout = err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            ch_reg         <= '0;
            rr_ptr_reg     <= '0;
            we_reg         <= 1'b0;
            tcnt_reg       <= '0;
            rsp_valid_reg  <= '0;
            rsp_rdata_reg  <= '0;
            cache_ren_reg  <= 1'b0;
            cache_wen_reg  <= 1'b0;
            cache_addr_reg <= '0;
            cache_dout_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            rsp_valid_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        ch_reg         <= grant_ch;
                        we_reg         <= bus.req_we[grant_ch];
                        cache_addr_reg <= ch_addr[grant_ch];
                        cache_dout_reg <= ch_wdata[grant_ch];
                        cache_ren_reg  <= ~bus.req_we[grant_ch];
                        cache_wen_reg  <= bus.req_we[grant_ch];
                        tcnt_reg       <= '0;
                        state_reg      <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.cache_rdy) begin
                        rsp_rdata_reg          <= we_reg ? '0 : bus.cache_din;
                        cache_ren_reg          <= 1'b0;
                        cache_wen_reg          <= 1'b0;
                        rsp_valid_reg[ch_reg]  <= 1'b1;
                        state_reg              <= RESP;
                    end else if (TIMEOUT != 0 && tcnt_reg == TLIM) begin
                        // Abort: the requester still gets a response so its stage unfreezes.
                        err_reg                <= 1'b1;
                        rsp_rdata_reg          <= '0;
                        cache_ren_reg          <= 1'b0;
                        cache_wen_reg          <= 1'b0;
                        rsp_valid_reg[ch_reg]  <= 1'b1;
                        state_reg              <= RESP;
                    end else begin
                        tcnt_reg <= tcnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    tcnt_reg   <= '0;
                    rr_ptr_reg <= (ch_reg == CW'(N_CH - 1)) ? '0 : ch_reg + 1'b1;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one stimulus stream and are
// checked every cycle against a transaction-level model, plus hand-computed literal expectations.
module tb_mem_port_arbiter;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  t_valid, t_we;
    logic [31:0] t_a0, t_a1, t_w0, t_w1, t_din;
    logic        t_rdy;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.N_CH(2), .AW(32), .DW(32)) bus_rr ();
    mem_port_arbiter_if #(.N_CH(2), .AW(32), .DW(32)) bus_fp ();

    mem_port_arbiter #(.N_CH(2), .AW(32), .DW(32), .FIXED_PRIO(0), .TIMEOUT(TO)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus(bus_rr.slave));
    mem_port_arbiter #(.N_CH(2), .AW(32), .DW(32), .FIXED_PRIO(1), .TIMEOUT(TO)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(bus_fp.slave));

    assign bus_rr.req_valid = t_valid;        assign bus_fp.req_valid = t_valid;
    assign bus_rr.req_we    = t_we;           assign bus_fp.req_we    = t_we;
    assign bus_rr.req_addr  = {t_a1, t_a0};   assign bus_fp.req_addr  = {t_a1, t_a0};
    assign bus_rr.req_wdata = {t_w1, t_w0};   assign bus_fp.req_wdata = {t_w1, t_w0};
    assign bus_rr.cache_rdy = t_rdy;          assign bus_fp.cache_rdy = t_rdy;
    assign bus_rr.cache_din = t_din;          assign bus_fp.cache_din = t_din;

    logic [1:0]  o_ack [2], o_rsp [2], o_stall [2];
    logic        o_ren [2], o_wen [2], o_err [2];
    logic [31:0] o_addr [2], o_dout [2], o_rdata [2];

    assign o_ack[0] = bus_rr.req_ack;      assign o_ack[1] = bus_fp.req_ack;
    assign o_rsp[0] = bus_rr.rsp_valid;    assign o_rsp[1] = bus_fp.rsp_valid;
    assign o_stall[0] = bus_rr.stall;      assign o_stall[1] = bus_fp.stall;
    assign o_ren[0] = bus_rr.cache_ren;    assign o_ren[1] = bus_fp.cache_ren;
    assign o_wen[0] = bus_rr.cache_wen;    assign o_wen[1] = bus_fp.cache_wen;
    assign o_err[0] = bus_rr.err_timeout;  assign o_err[1] = bus_fp.err_timeout;
    assign o_addr[0] = bus_rr.cache_addr;  assign o_addr[1] = bus_fp.cache_addr;
    assign o_dout[0] = bus_rr.cache_dout;  assign o_dout[1] = bus_fp.cache_dout;
    assign o_rdata[0] = bus_rr.rsp_rdata;  assign o_rdata[1] = bus_fp.rsp_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Same literal expectation for both arbiters.
    task automatic lit(input string nm, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] exp);
        chk({nm, "_rr"}, a0, exp);
        chk({nm, "_fp"}, a1, exp);
    endtask

    // Model: which channel wins given the requests, the rotation start and the priority mode.
    function automatic int pick(input logic [1:0] req, input int rr, input bit fixed);
        for (int k = 0; k < 2; k++) begin
            int c;
            c = fixed ? k : (rr + k) % 2;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    // Model state: one outstanding transaction per arbiter, tracked by its lifecycle phase
    // (0 no transaction, 1 at the cache, 2 being answered) and the cycles it has waited.
    int          m_ph [2], m_ch [2], m_rr [2], m_wait [2];
    logic        m_we [2], m_err [2];
    logic [31:0] m_addr [2], m_wd [2], m_rdata [2];

    int          ph, ch, rr, wt, w;
    logic        we_l, err_l;
    logic [31:0] addr_l, wd_l, rdata_l;
    logic [1:0]  e_ack, e_rsp;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            ph = m_ph[d]; ch = m_ch[d]; rr = m_rr[d]; wt = m_wait[d];
            we_l = m_we[d]; err_l = m_err[d]; addr_l = m_addr[d]; wd_l = m_wd[d];
            rdata_l = m_rdata[d];
            if (!rst_n) begin
                ph = 0; ch = 0; rr = 0; wt = 0; we_l = 0; err_l = 0;
                addr_l = 0; wd_l = 0; rdata_l = 0;
            end
            w = pick(t_valid, rr, d == 1);
            e_ack = '0;
            if (ph == 0 && w >= 0) e_ack[w] = 1'b1;
            e_rsp = '0;
            if (ph == 2) e_rsp[ch] = 1'b1;
            chk($sformatf("cyc_ack_d%0d", d), 32'(o_ack[d]), 32'(e_ack));
            chk($sformatf("cyc_rsp_d%0d", d), 32'(o_rsp[d]), 32'(e_rsp));
            chk($sformatf("cyc_stall_d%0d", d), 32'(o_stall[d]), 32'(t_valid & ~e_rsp));
            chk($sformatf("cyc_ren_d%0d", d), 32'(o_ren[d]), 32'(ph == 1 && !we_l));
            chk($sformatf("cyc_wen_d%0d", d), 32'(o_wen[d]), 32'(ph == 1 && we_l));
            chk($sformatf("cyc_err_d%0d", d), 32'(o_err[d]), 32'(err_l));
            chk($sformatf("cyc_rdata_d%0d", d), o_rdata[d], rdata_l);
            if (ph == 1 || !rst_n) begin
                chk($sformatf("cyc_addr_d%0d", d), o_addr[d], addr_l);
                chk($sformatf("cyc_dout_d%0d", d), o_dout[d], wd_l);
            end
            if (e_rsp != 2'b00)
                $display("t=%0t dut%0d ch%0d %s done rdata=%h err=%0d", $time, d, ch,
                         we_l ? "write" : "read", rdata_l, err_l);
            if (rst_n) begin
                if (ph == 0) begin
                    if (w >= 0) begin
                        ch = w; we_l = t_we[w];
                        addr_l = (w == 1) ? t_a1 : t_a0;
                        wd_l   = (w == 1) ? t_w1 : t_w0;
                        wt = 0; ph = 1;
                    end
                end else if (ph == 1) begin
                    if (t_rdy) begin
                        rdata_l = we_l ? 32'h0 : t_din; ph = 2;
                    end else if (wt == TO - 1) begin
                        err_l = 1'b1; rdata_l = 32'h0; ph = 2;
                    end else begin
                        wt = wt + 1;
                    end
                end else begin
                    rr = (ch + 1) % 2; ph = 0;
                end
            end
            m_ph[d] <= ph; m_ch[d] <= ch; m_rr[d] <= rr; m_wait[d] <= wt;
            m_we[d] <= we_l; m_err[d] <= err_l; m_addr[d] <= addr_l; m_wd[d] <= wd_l;
            m_rdata[d] <= rdata_l;
        end
    end

    // Apply one cycle of stimulus just after the rising edge, return at the falling edge.
    task automatic drive(input logic rst, input logic [1:0] v, input logic [1:0] we,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input logic rdy, input logic [31:0] din);
        @(posedge clk);
        #1;
        rst_n = rst; t_valid = v; t_we = we; t_a0 = a0; t_a1 = a1;
        t_w0 = w0; t_w1 = w1; t_rdy = rdy; t_din = din;
        @(negedge clk);
    endtask

    int gch [2][8], gcy [2][8], ng [2], first [2];
    bit fp_stall1_low, rsp0_after_rst;

    initial begin
        rst_n = 1'b0; t_valid = '0; t_we = '0; t_a0 = '0; t_a1 = '0;
        t_w0 = '0; t_w1 = '0; t_rdy = 1'b0; t_din = '0;

        // Reset state
        drive(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        drive(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        lit("rst_ren", 32'(o_ren[0]), 32'(o_ren[1]), 0);
        lit("rst_rsp", 32'(o_rsp[0]), 32'(o_rsp[1]), 0);
        lit("rst_rdata", o_rdata[0], o_rdata[1], 0);
        lit("rst_err", 32'(o_err[0]), 32'(o_err[1]), 0);
        drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);

        // ch0 write, request dropped after ack, cache ready on third BUSY cycle
        drive(1, 2'b01, 2'b01, 32'h40, 0, 32'h12345678, 0, 0, 0);
        lit("wr_ack", 32'(o_ack[0]), 32'(o_ack[1]), 32'h1);
        drive(1, 2'b01, 2'b01, 32'h40, 0, 32'h12345678, 0, 0, 0);
        lit("wr_wen", 32'(o_wen[0]), 32'(o_wen[1]), 1);
        lit("wr_dout", o_dout[0], o_dout[1], 32'h12345678);
        drive(1, 2'b00, 2'b00, 32'hFFF, 0, 0, 0, 0, 0);
        lit("wr_addr_hold", o_addr[0], o_addr[1], 32'h40);
        drive(1, 2'b00, 2'b00, 32'hFFF, 0, 0, 0, 1, 32'hAAAA5555);
        lit("wr_wen_rdy", 32'(o_wen[0]), 32'(o_wen[1]), 1);
        drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        lit("wr_rsp", 32'(o_rsp[0]), 32'(o_rsp[1]), 32'h1);
        lit("wr_rdata", o_rdata[0], o_rdata[1], 0);
        drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);

        // ch1 read 0x100, ready on 2nd BUSY cycle
        drive(1, 2'b10, 2'b00, 0, 32'h100, 0, 0, 0, 0);
        lit("rd_ack", 32'(o_ack[0]), 32'(o_ack[1]), 32'h2);
        lit("rd_stall_t0", 32'(o_stall[0]), 32'(o_stall[1]), 32'h2);
        drive(1, 2'b10, 2'b00, 0, 32'h100, 0, 0, 0, 0);
        lit("rd_ren", 32'(o_ren[0]), 32'(o_ren[1]), 1);
        lit("rd_addr", o_addr[0], o_addr[1], 32'h100);
        drive(1, 2'b10, 2'b00, 0, 32'h100, 0, 0, 1, 32'hDEADBEEF);
        lit("rd_stall_t2", 32'(o_stall[0]), 32'(o_stall[1]), 32'h2);
        drive(1, 2'b10, 2'b00, 0, 32'h100, 0, 0, 0, 0);
        lit("rd_rsp", 32'(o_rsp[0]), 32'(o_rsp[1]), 32'h2);
        lit("rd_rdata", o_rdata[0], o_rdata[1], 32'hDEADBEEF);
        lit("rd_stall_t3", 32'(o_stall[0]), 32'(o_stall[1]), 0);
        drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        lit("rd_rdata_hold", o_rdata[0], o_rdata[1], 32'hDEADBEEF);

        // Both channels held valid, cache always ready
        ng[0] = 0; ng[1] = 0; fp_stall1_low = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1, 2'b11, 2'b00, 32'h200, 32'h300, 0, 0, 1, 32'h0BADF00D);
            for (int d = 0; d < 2; d++)
                if (o_ack[d] != 2'b00 && ng[d] < 8) begin
                    gch[d][ng[d]] = o_ack[d][1] ? 1 : 0;
                    gcy[d][ng[d]] = i;
                    ng[d]++;
                end
            if (!o_stall[1][1]) fp_stall1_low = 1;
        end
        lit("arb_ngrants", 32'(ng[0]), 32'(ng[1]), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_grant%0d", k), 32'(gch[0][k]), 32'(k % 2));
            chk($sformatf("fp_grant%0d", k), 32'(gch[1][k]), 0);
            if (k > 0) lit($sformatf("arb_spacing%0d", k),
                           32'(gcy[0][k] - gcy[0][k-1]), 32'(gcy[1][k] - gcy[1][k-1]), 3);
        end
        chk("fp_stall1_low", 32'(fp_stall1_low), 0);
        drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
        drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);

        // Watchdog: cache never ready
        first[0] = -1; first[1] = -1;
        for (int i = 0; i < 8; i++) begin
            drive(1, (i == 0) ? 2'b01 : 2'b00, 2'b00, 32'h500, 0, 0, 0, 0, 32'h5555AAAA);
            for (int d = 0; d < 2; d++)
                if (o_rsp[d][0] && first[d] < 0) first[d] = i;
            if (i == 4) lit("to_err_before", 32'(o_err[0]), 32'(o_err[1]), 0);
            if (i == 5) begin
                lit("to_err_set", 32'(o_err[0]), 32'(o_err[1]), 1);
                lit("to_rdata", o_rdata[0], o_rdata[1], 0);
            end
        end
        lit("to_rsp_cycle", 32'(first[0]), 32'(first[1]), 5);
        lit("to_err_sticky", 32'(o_err[0]), 32'(o_err[1]), 1);

        // Reset while the cache access is outstanding
        rsp0_after_rst = 0;
        drive(1, 2'b01, 2'b00, 32'h600, 0, 0, 0, 0, 0);
        drive(1, 2'b01, 2'b00, 32'h600, 0, 0, 0, 0, 0);
        drive(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        lit("mid_rst_ren", 32'(o_ren[0]), 32'(o_ren[1]), 0);
        lit("mid_rst_addr", o_addr[0], o_addr[1], 0);
        lit("mid_rst_err", 32'(o_err[0]), 32'(o_err[1]), 0);
        drive(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        drive(1, 2'b10, 2'b00, 0, 32'h700, 0, 0, 0, 0);
        lit("post_rst_ack", 32'(o_ack[0]), 32'(o_ack[1]), 32'h2);
        drive(1, 2'b10, 2'b00, 0, 32'h700, 0, 0, 1, 32'h77);
        drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
        lit("post_rst_rsp", 32'(o_rsp[0]), 32'(o_rsp[1]), 32'h2);
        lit("post_rst_rdata", o_rdata[0], o_rdata[1], 32'h77);
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
            if (o_rsp[0][0] || o_rsp[1][0]) rsp0_after_rst = 1;
        end
        chk("no_rsp_abandoned", 32'(rsp0_after_rst), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL time_limit: got no completion expected finish before 100000");
        $fatal(1, "time limit");
    end
endmodule
